// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg
//   Shared constants and types for the input debouncer.
//   DEF_TICK_DIV     : default clock cycles per sample tick (1 kHz at 50 MHz)
//   DEF_STABLE_TICKS : default ticks a new value must persist before acceptance
//   PRESS_CNT_W      : width of the optional channel-0 press counter
//   deb_state_t      : per-channel debounce state
package input_debounce_pkg;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 16;
  localparam int PRESS_CNT_W      = 8;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/input_debouncer_channel.sv
// debounce_channel
//   One debounced input bit. Only acts on sample-tick cycles: a synchronized
//   value that differs from the accepted level for STABLE_TICKS consecutive
//   ticks becomes the new level, with a one-cycle press/release strobe.
//   Ports:
//     gclk, grst_n : clock, async active-low reset
//     syncBit      : synchronized raw input
//     tick         : one-cycle sample enable
//     level        : debounced level
//     press        : strobe on debounced 0->1
//     relStb       : strobe on debounced 1->0
module debounce_channel
  import input_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic syncBit,
  input  logic tick,
  output logic level,
  output logic press,
  output logic relStb
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  deb_state_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, cntBase;
  logic             levelQ, levelNext;
  logic             pressQ, pressNext;
  logic             relQ, relNext;

  // state register
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state  <= STABLE;
      cnt    <= '0;
      levelQ <= 1'b0;
      pressQ <= 1'b0;
      relQ   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      levelQ <= levelNext;
      pressQ <= pressNext;
      relQ   <= relNext;
    end
  end

  // next-state: a tick that sees a match discards any partial run
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    levelNext = levelQ;
    pressNext = 1'b0;
    relNext   = 1'b0;
    // a run always starts from zero when leaving STABLE
    cntBase   = (state == CHANGING) ? cnt : '0;
    if (tick) begin
      if (syncBit == levelQ) begin
        stateNext = STABLE;
        cntNext   = '0;
      end else if (cntBase == CNT_LAST) begin
        stateNext = STABLE;
        cntNext   = '0;
        levelNext = syncBit;
        pressNext = syncBit;
        relNext   = ~syncBit;
      end else begin
        stateNext = CHANGING;
        cntNext   = cntBase + 1'b1;
      end
    end
  end

  // outputs: all registered, so strobes land on the same edge as the level
  always_comb begin
    level  = levelQ;
    press  = pressQ;
    relStb = relQ;
  end

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer
//   Debounces and edge-detects slow board inputs on the iCLK_50 domain.
//   Two-flop synchronizer per bit, a shared sample-tick divider, and one
//   debounce_channel per bit.
//   Optional feature macro: INPUT_DEBOUNCE_COUNT_EN adds oPRESS_CNT, a
//   wrapping count of channel-0 press strobes.
//   Ports:
//     iCLK_50    : clock
//     iRST_n     : async active-low reset
//     iRAW       : raw asynchronous inputs
//     oLEVEL     : debounced levels
//     oPRESS     : one-cycle press strobes
//     oRELEASE   : one-cycle release strobes
//     oTICK      : sample tick, one cycle every TICK_DIV cycles
//     oPRESS_CNT : channel-0 press count (macro only)
module input_debouncer
  import input_debounce_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                   iCLK_50,
  input  logic                   iRST_n,
  input  logic [N_IN-1:0]        iRAW,
  output logic [N_IN-1:0]        oLEVEL,
  output logic [N_IN-1:0]        oPRESS,
  output logic [N_IN-1:0]        oRELEASE,
  output logic                   oTICK
`ifdef INPUT_DEBOUNCE_COUNT_EN
  ,
  output logic [PRESS_CNT_W-1:0] oPRESS_CNT
`endif
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [N_IN-1:0]  syncMeta, syncQ;

  // tick is registered: high in the cycle after div hits its last value
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      div   <= '0;
      oTICK <= 1'b0;
    end else begin
      oTICK <= (div == DIV_LAST);
      div   <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      syncMeta <= '0;
      syncQ    <= '0;
    end else begin
      syncMeta <= iRAW;
      syncQ    <= syncMeta;
    end
  end

  for (genvar ch = 0; ch < N_IN; ch++) begin : gCh
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) uCh (
      .gclk    (iCLK_50),
      .grst_n  (iRST_n),
      .syncBit (syncQ[ch]),
      .tick    (oTICK),
      .level   (oLEVEL[ch]),
      .press   (oPRESS[ch]),
      .relStb  (oRELEASE[ch])
    );
  end

`ifdef INPUT_DEBOUNCE_COUNT_EN
  // wraps naturally at 2**PRESS_CNT_W
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n)        oPRESS_CNT <= '0;
    else if (oPRESS[0]) oPRESS_CNT <= oPRESS_CNT + 1'b1;
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int NI = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic          iCLK_50 = 1'b0;
  logic          iRST_n  = 1'b0;
  logic [NI-1:0] iRAW    = '0;
  logic [NI-1:0] oLEVEL, oPRESS, oRELEASE;
  logic          oTICK;
`ifdef INPUT_DEBOUNCE_COUNT_EN
  logic [7:0]    oPRESS_CNT;
`endif

  input_debouncer #(.N_IN(NI), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .iCLK_50  (iCLK_50),
    .iRST_n   (iRST_n),
    .iRAW     (iRAW),
    .oLEVEL   (oLEVEL),
    .oPRESS   (oPRESS),
    .oRELEASE (oRELEASE),
    .oTICK    (oTICK)
`ifdef INPUT_DEBOUNCE_COUNT_EN
    ,
    .oPRESS_CNT (oPRESS_CNT)
`endif
  );

  always #10 iCLK_50 = ~iCLK_50;

  int total = 0;
  int bad   = 0;

  // reference model: raw input seen two edges late, tick every TD edges
  // since reset release, per-channel run length of mismatching ticks
  logic [NI-1:0] mS1, mS2, mLevel, mPress, mRel;
  logic          mTick;
  int            mCyc;
  int            mRun [NI];
  int            mPcnt;
  int            pressSeen [NI];
  int            relSeen [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mLevel = '0; mPress = '0; mRel = '0;
    mTick = 1'b0; mCyc = 0; mPcnt = 0;
    for (int c = 0; c < NI; c++) mRun[c] = 0;
  endtask

  task automatic clearSeen();
    for (int c = 0; c < NI; c++) begin pressSeen[c] = 0; relSeen[c] = 0; end
  endtask

  // one clock: predict, take the edge, compare, return at the negedge
  task automatic step();
    logic [NI-1:0] nS1, nS2, nLevel, nPress, nRel;
    logic          nTick;
    int            nRun [NI];
    int            nPcnt;
    nS1 = iRAW; nS2 = mS1; nLevel = mLevel; nPress = '0; nRel = '0;
    nTick = ((mCyc + 1) % TD == 0);
    nPcnt = mPress[0] ? (mPcnt + 1) % 256 : mPcnt;
    for (int c = 0; c < NI; c++) begin
      nRun[c] = mRun[c];
      if (mTick) begin
        if (mS2[c] == mLevel[c]) nRun[c] = 0;
        else if (mRun[c] + 1 >= ST) begin
          nRun[c] = 0;
          nLevel[c] = mS2[c];
          if (mS2[c]) nPress[c] = 1'b1; else nRel[c] = 1'b1;
        end else nRun[c] = mRun[c] + 1;
      end
    end
    @(posedge iCLK_50);
    #1;
    if (iRST_n) begin
      mS1 = nS1; mS2 = nS2; mLevel = nLevel; mPress = nPress; mRel = nRel;
      mTick = nTick; mRun = nRun; mPcnt = nPcnt; mCyc++;
    end
    check("level", oLEVEL, mLevel);
    check("press", oPRESS, mPress);
    check("release", oRELEASE, mRel);
    check("tick", oTICK, mTick);
`ifdef INPUT_DEBOUNCE_COUNT_EN
    check("press_cnt", oPRESS_CNT, mPcnt);
`endif
    for (int c = 0; c < NI; c++) begin
      if (oPRESS[c] === 1'b1) pressSeen[c]++;
      if (oRELEASE[c] === 1'b1) relSeen[c]++;
    end
    @(negedge iCLK_50);
  endtask

  task automatic waitLevel(input int ch, input logic val, input int maxc, output int n);
    n = 0;
    while (oLEVEL[ch] !== val && n < maxc) begin
      step();
      n++;
    end
    check("wait_level", oLEVEL[ch], val);
  endtask

  task automatic doReset();
    iRST_n = 1'b0;
    #1;
    modelReset();
    check("rst_level", oLEVEL, 0);
    check("rst_press", oPRESS, 0);
    check("rst_release", oRELEASE, 0);
    check("rst_tick", oTICK, 0);
    step(); step();
    @(negedge iCLK_50);
    iRST_n = 1'b1;
  endtask

  int n;

  initial begin
    modelReset();
    clearSeen();
    @(negedge iCLK_50);

    // reset with all inputs high: everything stays 0
    iRAW = 4'hF;
    step(); step(); step();
    check("rst_hold_level", oLEVEL, 0);
    check("rst_hold_tick", oTICK, 0);
    iRAW = 4'h0;
    iRST_n = 1'b1;
    // tick phase: cycles 4, 8, 12 after release
    for (int c = 1; c <= 13; c++) begin
      step();
      check("tick_phase", oTICK, (c % TD == 0));
    end

    // clean press on channel 0
    clearSeen();
    iRAW[0] = 1'b1;
    waitLevel(0, 1'b1, 30, n);
    check("press_lat_lo", (n >= 11), 1);
    check("press_lat_hi", (n <= 15), 1);
    check("press_on_edge", oPRESS[0], 1'b1);
    step(); step();
    check("press_once", pressSeen[0], 1);
    check("no_release", relSeen[0] + relSeen[1] + relSeen[2] + relSeen[3], 0);

    // glitch on channel 1: two ticks high, then low
    clearSeen();
    iRAW[1] = 1'b1;
    repeat (8) step();
    iRAW[1] = 1'b0;
    repeat (20) step();
    check("glitch_level", oLEVEL[1], 1'b0);
    check("glitch_strobes", pressSeen[1] + relSeen[1], 0);

    // release on channel 2
    iRAW[2] = 1'b1;
    waitLevel(2, 1'b1, 30, n);
    clearSeen();
    iRAW[2] = 1'b0;
    waitLevel(2, 1'b0, 30, n);
    check("release_on_edge", oRELEASE[2], 1'b1);
    step(); step();
    check("release_once", relSeen[2], 1);
    check("release_no_press", pressSeen[2], 0);

    // mid-debounce reset on channel 3 after two mismatching ticks
    iRAW[3] = 1'b1;
    n = 0;
    while (mRun[3] != 2 && n < 20) begin step(); n++; end
    check("mid_two_ticks", mRun[3], 2);
    check("mid_level_before", oLEVEL[3], 1'b0);
    doReset();
    waitLevel(3, 1'b1, 30, n);
    check("mid_full_restart", n, 13);

    // bounce on channel 1: alternates every tick
    clearSeen();
    for (int k = 0; k < 16; k++) begin
      iRAW[1] = ~iRAW[1];
      repeat (TD) step();
    end
    iRAW[1] = 1'b0;
    repeat (TD) step();
    check("bounce_level", oLEVEL[1], 1'b0);
    check("bounce_strobes", pressSeen[1] + relSeen[1], 0);

    // random activity against the model
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, NI - 1);
        iRAW[b] = ~iRAW[b];
      end
      step();
    end

`ifdef INPUT_DEBOUNCE_COUNT_EN
    // 257 presses on channel 0 wraps the counter to 1
    iRAW = '0;
    doReset();
    for (int k = 0; k < 257; k++) begin
      iRAW[0] = 1'b1;
      waitLevel(0, 1'b1, 30, n);
      iRAW[0] = 1'b0;
      waitLevel(0, 1'b0, 30, n);
    end
    step();
    check("press_cnt_wrap", oPRESS_CNT, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
